// File: rtl/xmit_pkg.sv
// rtl/xmit_pkg.sv - Shared types, defaults and descriptor helper for the transmit frame scheduler
package xmit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEND,
    ST_GAP,
    ST_DISCARD
  } xmit_state_t;

  localparam int DEF_LEN_W        = 12;
  localparam int DEF_MAX_LEN      = 1518;
  localparam int DEF_IFG_CYCLES   = 12;
  localparam int DEF_STARVE_LIMIT = 4;

  // Descriptor layout: length field at the bottom, its check copy directly above it.
  localparam int DESC_LEN_OFS = 0;

  function automatic logic desc_legal(input logic [31:0] len,
                                      input logic [31:0] chk,
                                      input logic [31:0] max_len);
    return (len == chk) && (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/xmit_prio_arbiter.sv
// rtl/xmit_prio_arbiter.sv - Strict-priority descriptor arbiter with low-priority starvation guard
module xmit_prio_arbiter
  import xmit_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic hi_valid,
  input  logic lo_valid,
  input  logic idle,
  output logic grant_hi,
  output logic grant_lo
);

  localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] hi_streak;
  logic                force_lo;

  always_comb begin
    force_lo = lo_valid && (STARVE_LIMIT > 0) && (hi_streak == STREAK_MAX);
    grant_lo = idle && (force_lo || (!hi_valid && lo_valid));
    grant_hi = idle && hi_valid && !force_lo;
  end

  // The streak only grows while low traffic is actually waiting behind a high grant.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hi_streak <= '0;
    end else if (grant_lo) begin
      hi_streak <= '0;
    end else if (grant_hi) begin
      if (!lo_valid) begin
        hi_streak <= '0;
      end else if (hi_streak != STREAK_MAX) begin
        hi_streak <= hi_streak + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/xmit_prio_scheduler.sv
// rtl/xmit_prio_scheduler.sv - Frame scheduler: picks hi/lo descriptors and sequences byte reads toward the PHY
module xmit_prio_scheduler
  import xmit_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int IFG_CYCLES   = DEF_IFG_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               hi_desc_valid,
  input  logic [2*LEN_W-1:0] hi_desc,
  output logic               hi_desc_pop,
  input  logic               lo_desc_valid,
  input  logic [2*LEN_W-1:0] lo_desc,
  output logic               lo_desc_pop,
  input  logic               phy_ready,
  output logic               data_rd_en,
  output logic               data_sel,
  output logic               frame_start,
  output logic               frame_end,
  output logic               m_discard_en,
  output logic               busy
);

  localparam int DESC_CHK_OFS = DESC_LEN_OFS + LEN_W;
  localparam int GAP_W        = $clog2(IFG_CYCLES + 2);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  xmit_state_t      state, state_nxt;
  logic [LEN_W-1:0] len_q, chk_q, cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_hi, grant_lo, legal;

  xmit_prio_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .hi_valid(hi_desc_valid),
    .lo_valid(lo_desc_valid),
    .idle    (state == ST_IDLE),
    .grant_hi(grant_hi),
    .grant_lo(grant_lo)
  );

  assign legal = desc_legal(32'(len_q), 32'(chk_q), 32'(MAX_LEN));
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_rd_en   = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    m_discard_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_hi || grant_lo) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = legal ? ST_SEND : ST_DISCARD;
      end
      ST_SEND: begin
        data_rd_en  = phy_ready;
        frame_start = phy_ready && (cnt == len_q);
        frame_end   = phy_ready && (cnt == LEN_W'(1));
        if (frame_end) state_nxt = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      ST_DISCARD: begin
        // Flush ignores phy_ready: discarded bytes never reach the serializer.
        m_discard_en = 1'b1;
        data_rd_en   = (cnt != '0);
        if (cnt <= LEN_W'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      chk_q       <= '0;
      data_sel    <= 1'b0;
      cnt         <= '0;
      gap_cnt     <= '0;
      hi_desc_pop <= 1'b0;
      lo_desc_pop <= 1'b0;
    end else begin
      hi_desc_pop <= grant_hi;
      lo_desc_pop <= grant_lo;
      if (grant_hi) begin
        len_q    <= hi_desc[DESC_LEN_OFS +: LEN_W];
        chk_q    <= hi_desc[DESC_CHK_OFS +: LEN_W];
        data_sel <= 1'b1;
      end else if (grant_lo) begin
        len_q    <= lo_desc[DESC_LEN_OFS +: LEN_W];
        chk_q    <= lo_desc[DESC_CHK_OFS +: LEN_W];
        data_sel <= 1'b0;
      end
      // A legal length never exceeds MAX_LEN, so one clamp serves both send and flush.
      case (state)
        ST_CHECK:            cnt <= (len_q > MAX_LEN_V) ? MAX_LEN_V : len_q;
        ST_SEND, ST_DISCARD: if (data_rd_en) cnt <= cnt - LEN_W'(1);
        default:             cnt <= cnt;
      endcase
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/xmit_prio_scheduler.md
Name: xmit_prio_scheduler

Overview:
- Frame-level scheduler ahead of the transmit datapath in xmitTop.
- Picks the next frame descriptor from the high-priority or low-priority queue, then sequences byte reads from the selected data queue toward the PHY serializer.
- Enforces an inter-frame gap and flushes malformed frames while asserting m_discard_en.
- Strict priority, with a starvation guard that forces one low-priority frame after a run of high-priority frames.

Parameters:
- LEN_W, 12, width of each length field in a descriptor.
- MAX_LEN, 1518, largest legal frame length in bytes.
- IFG_CYCLES, 12, idle clk_sys cycles after each sent frame.
- STARVE_LIMIT, 4, consecutive high frames allowed while low is pending; 0 disables the guard (pure strict priority).

Ports:
- clk_sys in 1: system clock.
- reset_n in 1: asynchronous active-low reset.
- hi_desc_valid in 1: high queue holds a descriptor.
- hi_desc in 2*LEN_W: high descriptor; [LEN_W-1:0] is the length, [2*LEN_W-1:LEN_W] is a copy used as a check.
- hi_desc_pop out 1: one-cycle pop of the high descriptor.
- lo_desc_valid in 1: low queue holds a descriptor.
- lo_desc in 2*LEN_W: low descriptor, same format as hi_desc.
- lo_desc_pop out 1: one-cycle pop of the low descriptor.
- phy_ready in 1: downstream accepts a byte this cycle.
- data_rd_en out 1: read one byte from the selected data queue.
- data_sel out 1: 1 = high data queue, 0 = low data queue.
- frame_start out 1: marks the first byte read of a sent frame.
- frame_end out 1: marks the last byte read of a sent frame.
- m_discard_en out 1: current frame is being discarded.
- busy out 1: state is not IDLE.

Behaviour:
- Reset:
  - reset_n low asynchronously forces IDLE.
  - Clears byte count, gap count, hi_streak and data_sel.
  - All outputs are 0 during and after reset.
  - Reset mid-frame abandons the frame; no frame_end is issued.
- State machine: IDLE, CHECK, SEND, GAP, DISCARD.
- IDLE:
  - Arbitration: if lo_desc_valid and STARVE_LIMIT>0 and hi_streak==STARVE_LIMIT, grant low; else if hi_desc_valid, grant high; else if lo_desc_valid, grant low.
  - On a grant: latch the descriptor and data_sel, go to CHECK.
  - With no valid descriptor, stay in IDLE.
- CHECK (exactly one cycle):
  - Registered pop of the granted queue is high for this cycle only.
  - Update hi_streak:
    - High grant with lo_desc_valid sampled at grant: hi_streak+1, saturating at STARVE_LIMIT.
    - High grant with low not valid: 0.
    - Low grant: 0.
  - Frame is legal when length field == check field, length != 0 and length <= MAX_LEN.
  - Legal: load the byte counter with the length, go to SEND.
  - Illegal: go to DISCARD.
- SEND:
  - data_rd_en = phy_ready (combinational).
  - Each read decrements the counter.
  - frame_start = data_rd_en && counter==length.
  - frame_end = data_rd_en && counter==1.
  - A length-1 frame asserts frame_start and frame_end together.
  - phy_ready low stalls with no read and no counter change.
  - After the last read, go to GAP.
- GAP:
  - IFG_CYCLES cycles with data_rd_en=0, then IDLE.
  - Descriptors arriving during GAP wait.
  - With IFG_CYCLES=0, go straight from SEND to IDLE.
- DISCARD:
  - m_discard_en=1 for the whole state.
  - Flush count = length field, clamped to MAX_LEN.
  - data_rd_en=1 every cycle, independent of phy_ready, until the flush count is exhausted.
  - frame_start and frame_end stay 0.
  - If the flush count is 0, DISCARD lasts one cycle with no reads.
  - Then go to IDLE; no gap is inserted.
- Latency:
  - Descriptor valid in IDLE to the first possible data_rd_en is 2 cycles (IDLE, CHECK, then SEND).
  - Back-to-back frames are separated by IFG_CYCLES+2 cycles without reads.
- Width rules:
  - Counters are LEN_W bits with no wrap.
  - hi_streak is clog2(STARVE_LIMIT+1) bits and saturates.
- data_sel is held constant from CHECK through the exit of SEND or DISCARD.

Decomposition:
- Package xmit_pkg holds:
  - State enum.
  - Descriptor field offsets/widths.
  - MAX_LEN and IFG defaults.
  - A shared descriptor-legality function.
- One sub-module, xmit_prio_arbiter:
  - Inputs: both valids, hi_streak, state==IDLE.
  - Outputs: grant_hi, grant_lo.
  - Owns the hi_streak counter and its saturation logic.

Test Plan:
- Alternating traffic: hi desc 0x200200 and lo desc 0x040040 both valid, phy_ready=1 -> hi frame with 512 reads, data_sel=1; 12-cycle gap; lo frame with 64 reads, data_sel=0; each frame has exactly one frame_start and one frame_end.
- Starvation guard: hi valid continuously with 0x040040 and lo valid with 0x040040, STARVE_LIMIT=4 -> grant order is H,H,H,H,L,H,H,H,H,L; hi_streak returns to 0 after each L.
- Malformed descriptor: hi desc 0x010020 (copy mismatch) -> m_discard_en high for 32 cycles with 32 data_rd_en; no frame_start or frame_end; then IDLE with no gap. Desc 0x000000 -> a single discard cycle with no reads.
- Backpressure: desc 0x008008, phy_ready toggling 1,0,1,0 -> exactly 8 reads, each only when phy_ready=1; frame_end lands on the 8th read; the counter holds while phy_ready=0.
- Reset mid-frame: reset_n pulled low after 100 of 512 reads -> all outputs 0 immediately and state IDLE; after release, a fresh desc 0x040040 is processed normally from CHECK.
- Length edge: desc 0x001001 -> frame_start and frame_end in the same cycle. Desc 0x5EF5EF (1519 > MAX_LEN) -> discard of 1518 reads.
